// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-memory write bus for mips_instr_encoder.
// master: the encoder (accepts requests, drives memory writes).
// slave : the requester / memory side.
interface mips_instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_op;
   logic [4:0]        req_rs;
   logic [4:0]        req_rt;
   logic [4:0]        req_rd;
   logic [25:0]       req_imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              imem_ready;

   modport master (
      input  req_valid, req_op, req_rs, req_rt, req_rd, req_imm, imem_ready,
      output req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output req_valid, req_op, req_rs, req_rt, req_rd, req_imm, imem_ready,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder and program loader.
// Packs symbolic requests into 32-bit words, buffers them in a small FIFO and
// writes them sequentially into instruction memory starting at BASE_ADDR.
// Optional build macro ENC_ERR_CHECK_EN: illegal ops are dropped and flagged,
// and logical/LUI immediates with non-zero upper bits are flagged, on o_err.
//
// state | meaning
// IDLE  | no session open, intake closed
// LOAD  | accepting requests and writing buffered words
// FLUSH | intake closed, draining FIFO to memory
// DONE  | session complete, word count held
module mips_instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_finish,
   mips_instr_encoder_if.master bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [ADDR_W-1:0]    o_word_count,
   output logic                 o_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LP_BASE = BASE_ADDR[ADDR_W-1:0];

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [31:0]        r_mem [DEPTH];
   logic [PTR_W:0]     r_wr_ptr;
   logic [PTR_W:0]     r_rd_ptr;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [ADDR_W-1:0]  r_word_count;
   logic [31:0]        w_word;
   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_push;
   logic               w_pop;
   logic               w_session_start;
   logic               w_last_pop;

   // Combinational packing of the request fields into a MIPS word
   always_comb begin
      w_word = 32'h0000_0000;
      case (bus.req_op)
         5'd0:  w_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20};
         5'd1:  w_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22};
         5'd2:  w_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h24};
         5'd3:  w_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h25};
         5'd4:  w_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h2A};
         5'd5:  w_word = {6'h00, bus.req_rs, 5'd0, 5'd0, 5'd0, 6'h08};
         5'd6:  w_word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd7:  w_word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd8:  w_word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd9:  w_word = {6'h05, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd10: w_word = {6'h08, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd11: w_word = {6'h0C, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd12: w_word = {6'h0D, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd13: w_word = {6'h0E, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         5'd14: w_word = {6'h02, bus.req_imm};
         5'd15: w_word = {6'h03, bus.req_imm};
         5'd16: w_word = {6'h0F, 5'd0, bus.req_rt, bus.req_imm[15:0]};
         5'd17: w_word = {6'h0B, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
         default: w_word = 32'h0000_0000;
      endcase
   end

   assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_empty  = (r_wr_ptr == r_rd_ptr);
   assign w_accept = bus.req_valid && bus.req_ready;
   assign w_pop    = bus.imem_we && bus.imem_ready;
   assign w_session_start = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   // Only FLUSH uses this; no pushes happen there, so one entry left plus a pop means empty
   assign w_last_pop = w_pop && ((r_rd_ptr + 1'b1) == r_wr_ptr);

`ifdef ENC_ERR_CHECK_EN
   logic w_illegal;
   logic w_imm_hi;
   logic r_err;

   assign w_illegal = (bus.req_op > 5'd17);
   assign w_imm_hi  = ((bus.req_op == 5'd11) || (bus.req_op == 5'd12) ||
                       (bus.req_op == 5'd13) || (bus.req_op == 5'd16)) &&
                      (bus.req_imm[25:16] != 10'd0);
   assign w_push    = w_accept && !w_illegal;

   // Sticky error flag, cleared only by reset or a new session
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if (w_session_start)
         r_err <= 1'b0;
      else if (w_accept && (w_illegal || w_imm_hi))
         r_err <= 1'b1;
   end

   assign o_err = r_err;
`else
   assign w_push = w_accept;
   assign o_err  = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_LOAD;
         S_LOAD:  if (i_finish) w_state_next = S_FLUSH;
         S_FLUSH: if (w_empty || w_last_pop) w_state_next = S_DONE;
         S_DONE:  if (i_start) w_state_next = S_LOAD;
         default: w_state_next = S_IDLE;
      endcase
   end

   // FIFO storage, pointers, write address and word counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0000_0000;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_wr_addr    <= LP_BASE;
         r_word_count <= '0;
      end else if (w_session_start) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_wr_addr    <= LP_BASE;
         r_word_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr     <= r_rd_ptr + 1'b1;
            r_wr_addr    <= r_wr_addr + ADDR_W'(4);
            r_word_count <= r_word_count + 1'b1;
         end
      end
   end

   assign bus.req_ready  = (r_state == S_LOAD) && !w_full;
   assign bus.imem_we    = !w_empty && ((r_state == S_LOAD) || (r_state == S_FLUSH));
   assign bus.imem_addr  = r_wr_addr;
   assign bus.imem_wdata = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign o_busy         = (r_state == S_LOAD) || (r_state == S_FLUSH);
   assign o_done         = (r_state == S_DONE);
   assign o_word_count   = r_word_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder (BASE_ADDR=0, ADDR_W=10, DEPTH=4).
module tb_mips_instr_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_start;
   logic       i_finish;
   logic       o_busy;
   logic       o_done;
   logic [9:0] o_word_count;
   logic       o_err;

   mips_instr_encoder_if #(.ADDR_W(10)) bus();

   mips_instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (i_start),
      .i_finish     (i_finish),
      .bus          (bus),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_word_count (o_word_count),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         last_wr_cyc = 0;
   logic [9:0] exp_addr = '0;
   int         exp_cnt = 0;
   bit         exp_err = 0;
   bit         rnd_ready = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference encoder: returns word, whether it is written, and whether it flags err
   function automatic void model(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [25:0] imm,
                                 output logic [31:0] w, output bit push, output bit err);
      logic [5:0] funct_tbl [6];
      logic [5:0] opc_tbl [18];
      funct_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
      opc_tbl   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04,
                    6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h02, 6'h03, 6'h0F, 6'h0B};
      push = 1;
      err  = 0;
      if (op <= 5'd4)       w = {6'h00, rs, rt, rd, 5'd0, funct_tbl[op]};
      else if (op == 5'd5)  w = {6'h00, rs, 15'd0, funct_tbl[5]};
      else if (op == 5'd14 || op == 5'd15) w = {opc_tbl[op], imm};
      else if (op == 5'd16) w = {opc_tbl[op], 5'd0, rt, imm[15:0]};
      else if (op <= 5'd17) w = {opc_tbl[op], rs, rt, imm[15:0]};
      else                  w = 32'h0;
`ifdef ENC_ERR_CHECK_EN
      if (op > 5'd17) begin push = 0; err = 1; end
      if ((op == 5'd11 || op == 5'd12 || op == 5'd13 || op == 5'd16) && imm[25:16] != 10'd0) err = 1;
`endif
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      if (rnd_ready) bus.imem_ready = 1'($urandom_range(0, 1));
   end

   // Write monitor: every completed write must match the scoreboard head
   always @(negedge clk) begin
      if (rst_n && bus.imem_we && bus.imem_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", {22'd0, bus.imem_addr}, {22'd0, e.addr});
            check("wr_data", bus.imem_wdata, e.data);
         end
         last_wr_cyc = cyc;
      end
   end

   task automatic do_start();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      exp_addr = '0;
      exp_cnt = 0;
      exp_err = 0;
   endtask

   task automatic do_finish();
      i_finish = 1'b1;
      @(posedge clk); #1;
      i_finish = 1'b0;
   endtask

   task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, input bit fin);
      int t;
      logic [31:0] w;
      bit p, e;
      bus.req_op = op; bus.req_rs = rs; bus.req_rt = rt; bus.req_rd = rd; bus.req_imm = imm;
      bus.req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (bus.req_ready) begin
         i_finish = fin;
         model(op, rs, rt, rd, imm, w, p, e);
         if (p) begin
            sb.push_back('{addr: exp_addr, data: w});
            exp_addr = exp_addr + 10'd4;
            exp_cnt++;
         end
         if (e) exp_err = 1;
      end else begin
         check("req_ready_timeout", 32'd0, 32'd1);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      i_finish = 1'b0;
   endtask

   task automatic wait_done(output int done_cyc);
      int t;
      t = 0;
      done_cyc = 0;
      @(negedge clk);
      while (!o_done && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (o_done) done_cyc = cyc;
      else check("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic end_session(input string tag, input int exp_words);
      int dc;
      wait_done(dc);
      check({tag, "_done"}, 32'(o_done), 32'd1);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_count"}, 32'(o_word_count), 32'(exp_words));
      check({tag, "_err"}, 32'(o_err), 32'(exp_err));
   endtask

   initial begin
      int dc;
      rst_n = 1'b0; i_start = 1'b0; i_finish = 1'b0;
      bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rs = '0; bus.req_rt = '0;
      bus.req_rd = '0; bus.req_imm = '0; bus.imem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_we", 32'(bus.imem_we), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_addr", 32'(bus.imem_addr), 32'd0);
      check("rst_wdata", bus.imem_wdata, 32'd0);
      check("rst_count", 32'(o_word_count), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      @(posedge clk); #1;

      // ADD rd=3 rs=1 rt=2, with one-cycle latency to imem_we
      do_start();
      send(5'd0, 5'd1, 5'd2, 5'd3, 26'd0, 0);
      @(negedge clk);
      check("latency_we", 32'(bus.imem_we), 32'd1);
      @(posedge clk); #1;
      do_finish();
      end_session("add", 1);

      // ADDI then LUI (rs forced to 0)
      do_start();
      send(5'd10, 5'd0, 5'd8, 5'd0, 26'h0005, 0);
      send(5'd16, 5'd7, 5'd1, 5'd0, 26'h1234, 0);
      do_finish();
      end_session("addi_lui", 2);

      // JAL then JR (rt/rd forced to 0)
      do_start();
      send(5'd15, 5'd0, 5'd0, 5'd0, 26'h0100000, 0);
      send(5'd5, 5'd31, 5'd5, 5'd6, 26'd0, 0);
      do_finish();
      end_session("jal_jr", 2);

      // Backpressure: fill FIFO, then drain at one word per cycle
      bus.imem_ready = 1'b0;
      do_start();
      for (int i = 0; i < 4; i++) send(5'd1, 5'(i), 5'(i + 1), 5'(i + 2), 26'd0, 0);
      @(negedge clk);
      check("full_ready", 32'(bus.req_ready), 32'd0);
      check("stall_addr", 32'(bus.imem_addr), 32'd0);
      @(posedge clk); #1;
      bus.imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("burst_we", 32'(bus.imem_we), 32'd1);
      end
      @(posedge clk); #1;
      send(5'd3, 5'd9, 5'd10, 5'd11, 26'd0, 0);
      do_finish();
      end_session("bp", 5);

      // finish on the same edge as the 3rd accept
      do_start();
      send(5'd2, 5'd4, 5'd5, 5'd6, 26'd0, 0);
      send(5'd6, 5'd29, 5'd8, 5'd0, 26'h0010, 0);
      send(5'd7, 5'd29, 5'd9, 5'd0, 26'hFFFC, 1);
      wait_done(dc);
      check("done_after_last_wr", 32'(dc - last_wr_cyc), 32'd1);
      check("fin_count", 32'(o_word_count), 32'd3);

      // Illegal op 20
      do_start();
      send(5'd20, 5'd1, 5'd2, 5'd3, 26'd0, 0);
      do_finish();
`ifdef ENC_ERR_CHECK_EN
      end_session("illegal", 0);
`else
      end_session("illegal", 1);
`endif

      // Reset during FLUSH discards pending words
      bus.imem_ready = 1'b0;
      do_start();
      send(5'd0, 5'd1, 5'd1, 5'd1, 26'd0, 0);
      send(5'd0, 5'd2, 5'd2, 5'd2, 26'd0, 0);
      do_finish();
      @(negedge clk);
      check("flush_busy", 32'(o_busy), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk);
      check("rstf_we", 32'(bus.imem_we), 32'd0);
      check("rstf_count", 32'(o_word_count), 32'd0);
      check("rstf_busy", 32'(o_busy), 32'd0);
      check("rstf_done", 32'(o_done), 32'd0);
      check("rstf_addr", 32'(bus.imem_addr), 32'd0);
      @(posedge clk); #1;
      bus.imem_ready = 1'b1;

      // Random requests under random memory backpressure
      rnd_ready = 1;
      do_start();
      for (int i = 0; i < 24; i++)
         send(5'($urandom_range(0, 19)), 5'($urandom), 5'($urandom), 5'($urandom),
              26'($urandom), 0);
      do_finish();
      end_session("rand", exp_cnt);
      rnd_ready = 0;
      bus.imem_ready = 1'b1;

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Instruction-word encoder and program loader; the inverse of the main control decoder. It accepts symbolic instruction requests (operation plus register and immediate fields) over a valid/ready handshake and packs them into 32-bit MIPS words. Words are buffered in a small FIFO and written sequentially into instruction memory. Used by the boot/self-test path to build programs before the core leaves reset.

Parameters:
ADDR_W, 10, instruction-memory byte-address width.
BASE_ADDR, 0, first write address; bits [1:0] must be 0.
DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  pulse; opens a load session.
finish  in  1  pulse; closes request intake.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_op  in  5  symbolic op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 J, 15 JAL, 16 LUI, 17 SLTIU; 18-31 illegal.
req_rs / req_rt / req_rd  in  5 each  register fields.
req_imm  in  26  immediate in [15:0]; jump target in [25:0].
imem_we  out  1  write request.
imem_addr  out  ADDR_W  byte address.
imem_wdata  out  32  encoded word.
imem_ready  in  1  memory accepts the write this cycle.
busy  out  1  state is LOAD or FLUSH.
done  out  1  state is DONE.
word_count  out  ADDR_W  words written since the last start.
err  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE. FIFO empty. wr_addr = BASE_ADDR. word_count = 0. err = 0. Outputs req_ready, imem_we, busy and done are 0. imem_addr = BASE_ADDR. imem_wdata = 0.
- Encoding is combinational on the request fields; the word is pushed into the FIFO on the accept edge.
- R-type encoding: {6'h00, rs, rt, rd, 5'b0, funct}. funct values: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, JR 0x08. JR forces rt and rd to 0.
- I-type encoding: {op, rs, rt, imm[15:0]}. op values: LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, SLTIU 0x0B. LUI forces rs to 0.
- J-type encoding: {op, imm[25:0]} with J 0x02, JAL 0x03.
- State IDLE: req_ready = 0. start moves to LOAD; FIFO cleared, wr_addr = BASE_ADDR, word_count = 0, err cleared.
- State LOAD: req_ready = !fifo_full. No push while full, even when a pop happens in the same cycle. finish moves to FLUSH. A request accepted in the same cycle as finish is included in the session.
- State FLUSH: req_ready = 0. Moves to DONE on the cycle the FIFO becomes empty, i.e. after the last write completes.
- State DONE: done = 1. word_count holds. start re-enters LOAD as described for IDLE.
- start while in LOAD or FLUSH is ignored. finish outside LOAD is ignored.
- Write port: imem_we = !fifo_empty && (LOAD || FLUSH). imem_wdata is the FIFO head; imem_addr = wr_addr.
- A write completes when imem_we && imem_ready. On completion: pop the FIFO, wr_addr += 4 (wrapping modulo 2^ADDR_W), word_count += 1 (wrapping).
- While imem_ready = 0, imem_addr and imem_wdata stay stable.
- Latency: a request accepted at edge N presents imem_we = 1 during cycle N+1. Throughput is 1 word per cycle.
- Reset mid-session: everything returns to reset values and pending FIFO words are discarded.

Optional Feature:
ENC_ERR_CHECK_EN.
- Defined: an illegal req_op is accepted but not pushed, and sets err. Setting err also applies to ANDI, ORI, XORI or LUI when req_imm[25:16] != 0 (that request is still encoded and written). err clears only on start or reset.
- Undefined: an illegal req_op is encoded as 0x00000000 (NOP) and written normally. err is tied to 0.

Test Plan:
- start; ADD rd=3 rs=1 rt=2; finish -> one write of 0x00221820 at addr 0x000; then done=1, word_count=1.
- ADDI rt=8 rs=0 imm=0x0005, then LUI rt=1 rs=7 imm=0x1234 -> 0x20080005 at 0x000, then 0x3C011234 at 0x004.
- JAL imm=0x0100000, then JR rs=31 rt=5 rd=6 -> 0x0C100000, then 0x03E00008.
- imem_ready=0, push 5 requests with DEPTH=4 -> req_ready drops after the 4th accept; raise imem_ready -> writes at 0x000, 0x004, 0x008, 0x00C on consecutive cycles, then the 5th request is accepted.
- finish asserted on the same edge as the 3rd accept -> 3 words written; done rises the cycle after the 3rd write; word_count=3.
- req_op=20 -> macro undefined: 0x00000000 written. Macro defined: nothing written, err=1. Separately, rst_n=0 during FLUSH -> IDLE, imem_we=0, word_count=0.
